// File: rtl/tick_sched_pkg.sv
// Shared definitions for the tick scheduler: state encoding, default frame
// length and the state-transition rule.
package tick_sched_pkg;

  // 800 x 525 pixel-enable pulses per video frame.
  localparam int unsigned FRAME_PIX_DEFAULT = 420000;

  localparam logic [1:0] STATE_IDLE   = 2'd0;
  localparam logic [1:0] STATE_RUN    = 2'd1;
  localparam logic [1:0] STATE_PAUSED = 2'd2;

  typedef enum logic [1:0] {
    StIdle   = STATE_IDLE,
    StRun    = STATE_RUN,
    StPaused = STATE_PAUSED
  } sched_state_e;

  // game_over beats pause; pause only matters in RUN/PAUSED; start only in IDLE.
  function automatic sched_state_e sched_next_state(input sched_state_e cur,
                                                    input logic         start,
                                                    input logic         pause,
                                                    input logic         game_over);
    sched_state_e nxt;
    nxt = cur;
    if (game_over) begin
      nxt = StIdle;
    end else begin
      case (cur)
        StIdle:   if (start) nxt = StRun;
        StRun:    if (pause) nxt = StPaused;
        StPaused: if (pause) nxt = StRun;
        default:  nxt = StIdle;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/frame_counter.sv
// Pixel-enable divider (every 2nd clk) and per-frame pixel counter.
// frame_wrap is the combinational "last pixel of the frame" condition; frame_tick
// is its registered form, so it rises on the same edge that wraps the counter.
module frame_counter
  import tick_sched_pkg::*;
#(
  parameter int unsigned FRAME_PIX = FRAME_PIX_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en,
  output logic frame_wrap,
  output logic frame_tick
);

  localparam int unsigned CntW = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(FRAME_PIX - 1);

  logic            pix_en_q;
  logic [CntW-1:0] cnt_q;
  logic            frame_tick_q;

  assign frame_wrap = pix_en_q && (cnt_q == LastCnt);

  // Divider, pixel counter and registered frame boundary pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_en_q     <= 1'b0;
      cnt_q        <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      pix_en_q     <= ~pix_en_q;
      frame_tick_q <= frame_wrap;
      if (frame_wrap) begin
        cnt_q <= '0;
      end else if (pix_en_q) begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign pix_en     = pix_en_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: rtl/tick_scheduler.sv
// Game tick scheduler: IDLE/RUN/PAUSED FSM issuing game_tick every `speed`
// frames while running. Single-step while paused is built only when the
// TICK_SCHED_STEP_EN macro is defined; otherwise step is ignored.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int unsigned FRAME_PIX = FRAME_PIX_DEFAULT,
  parameter int unsigned SPEED_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic               step,
  input  logic               game_over,
  input  logic [SPEED_W-1:0] speed,
  output logic               pix_en,
  output logic               frame_tick,
  output logic               game_tick,
  output logic [1:0]         state
);

  localparam logic [SPEED_W-1:0] SpeedOne = SPEED_W'(1);

  logic               frame_wrap;
  sched_state_e       state_q;
  sched_state_e       state_d;
  logic [SPEED_W-1:0] elapsed_q;
  logic [SPEED_W-1:0] speed_q;
  logic [SPEED_W:0]   elapsed_inc;
  logic               game_tick_q;

`ifdef TICK_SCHED_STEP_EN
  logic pending_q;
`else
  logic unused_step;
  assign unused_step = step;
`endif

  frame_counter #(
    .FRAME_PIX (FRAME_PIX)
  ) u_frame_counter (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .frame_wrap (frame_wrap),
    .frame_tick (frame_tick)
  );

  assign state_d     = sched_next_state(state_q, start, pause, game_over);
  assign elapsed_inc = {1'b0, elapsed_q} + {{SPEED_W{1'b0}}, 1'b1};

  // FSM, speed capture, frames-elapsed counter and registered game_tick.
  // Ticks are decided on the frame_wrap edge so game_tick lines up with frame_tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      elapsed_q   <= '0;
      speed_q     <= SpeedOne;
      game_tick_q <= 1'b0;
`ifdef TICK_SCHED_STEP_EN
      pending_q   <= 1'b0;
`endif
    end else begin
      game_tick_q <= 1'b0;
      state_q     <= state_d;
      // The value captured here governs the following boundary.
      if (frame_wrap) begin
        speed_q <= (speed == '0) ? SpeedOne : speed;
      end
      case (state_q)
        StIdle: begin
          if (state_d == StRun) elapsed_q <= '0;
        end
        StRun: begin
          // >= so a speed reduction below the current count still ticks.
          if (state_d == StRun && frame_wrap) begin
            if (elapsed_inc >= {1'b0, speed_q}) begin
              game_tick_q <= 1'b1;
              elapsed_q   <= '0;
            end else begin
              elapsed_q <= elapsed_inc[SPEED_W-1:0];
            end
          end
        end
        StPaused: begin
`ifdef TICK_SCHED_STEP_EN
          if (state_d != StPaused) begin
            pending_q <= 1'b0;
          end else if (frame_wrap && pending_q) begin
            game_tick_q <= 1'b1;
            pending_q   <= 1'b0;
          end else if (step) begin
            pending_q <= 1'b1;
          end
`endif
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign game_tick = game_tick_q;
  assign state     = state_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler with FRAME_PIX=8 (frame_tick every 16 clk).
// Reference model works in clk counts since reset and frame-level counters.
module tb_tick_scheduler;

  localparam int unsigned FP     = 8;
  localparam int unsigned SW     = 4;
  localparam int unsigned PERIOD = 2 * FP;

`ifdef TICK_SCHED_STEP_EN
  localparam int STEP_TICKS = 1;
`else
  localparam int STEP_TICKS = 0;
`endif

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          start     = 1'b0;
  logic          pause     = 1'b0;
  logic          step      = 1'b0;
  logic          game_over = 1'b0;
  logic [SW-1:0] speed     = '0;
  logic          pix_en;
  logic          frame_tick;
  logic          game_tick;
  logic [1:0]    state;

  int cmp_count = 0;
  int mis_count = 0;
  int dut_gt    = 0;

  // Reference model state
  int n         = 0;   // rising edges since reset released
  int m_state   = 0;   // 0 idle, 1 run, 2 paused
  int m_elapsed = 0;
  int m_speed   = 1;
  bit m_pend    = 0;
  bit m_gt      = 0;

  tick_scheduler #(
    .FRAME_PIX (FP),
    .SPEED_W   (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pause      (pause),
    .step       (step),
    .game_over  (game_over),
    .speed      (speed),
    .pix_en     (pix_en),
    .frame_tick (frame_tick),
    .game_tick  (game_tick),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_count++;
    assert (obs === exp) else begin
      mis_count++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int  nxt;
    int  s;
    bit  bnd;
    if (rst) begin
      n = 0; m_state = 0; m_elapsed = 0; m_speed = 1; m_pend = 0; m_gt = 0;
    end else begin
      n++;
      bnd  = (n % PERIOD) == 0;
      m_gt = 0;
      if (game_over)                 nxt = 0;
      else if (m_state == 1 && pause) nxt = 2;
      else if (m_state == 2 && pause) nxt = 1;
      else if (m_state == 0 && start) nxt = 1;
      else                            nxt = m_state;
      if (m_state == 0 && nxt == 1) m_elapsed = 0;
      if (bnd && m_state == 1 && nxt == 1) begin
        if (m_elapsed + 1 >= m_speed) begin
          m_gt = 1;
          m_elapsed = 0;
        end else begin
          m_elapsed++;
        end
      end
      if (STEP_TICKS != 0) begin
        if (m_state == 2 && nxt == 2) begin
          if (bnd && m_pend) begin
            m_gt = 1;
            m_pend = 0;
          end else if (step) begin
            m_pend = 1;
          end
        end else begin
          m_pend = 0;
        end
      end
      if (bnd) begin
        s = int'(speed);
        m_speed = (s == 0) ? 1 : s;
      end
      m_state = nxt;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    if (game_tick === 1'b1) dut_gt++;
    check("pix_en", 32'(pix_en), 32'(n % 2 == 1));
    check("frame_tick", 32'(frame_tick), 32'(n > 0 && (n % PERIOD) == 0));
    check("game_tick", 32'(game_tick), 32'(m_gt));
    check("state", 32'(state), 32'(m_state));
  endtask

  task automatic run_cycles(input int k);
    for (int i = 0; i < k; i++) cyc();
  endtask

  // Runs until k more frame boundaries have been seen (by clk count).
  task automatic run_frames(input int k);
    int seen;
    seen = 0;
    while (seen < k) begin
      cyc();
      if (n > 0 && (n % PERIOD) == 0) seen++;
    end
  endtask

  task automatic pulse_pause();
    pause = 1'b1; cyc(); pause = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1; cyc(); step = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  initial begin
    int base;
    int r;

    // Reset and free-running frame timing in IDLE
    speed = 4'd3;
    run_cycles(3);
    rst = 1'b0;
    run_frames(2);
    check("idle_state", 32'(state), 32'd0);
    check("idle_no_game_tick", 32'(dut_gt), 32'd0);

    // RUN at speed 3: ticks on 3rd, 6th, 9th frame
    run_cycles(5);
    pulse_start();
    base = dut_gt;
    run_frames(9);
    check("speed3_ticks", 32'(dut_gt - base), 32'd3);

    // Pause at frame 2 of 3, hold 5 frames, resume
    run_frames(2);
    run_cycles(4);
    pulse_pause();
    check("paused_state", 32'(state), 32'd2);
    base = dut_gt;
    run_frames(5);
    check("paused_no_ticks", 32'(dut_gt - base), 32'd0);
    run_cycles(3);
    pulse_pause();
    check("resumed_state", 32'(state), 32'd1);
    base = dut_gt;
    run_frames(1);
    check("resume_tick", 32'(dut_gt - base), 32'd1);

    // Two steps within one paused frame
    run_cycles(4);
    pulse_pause();
    pulse_step();
    cyc();
    pulse_step();
    base = dut_gt;
    run_frames(1);
    check("step_ticks", 32'(dut_gt - base), 32'(STEP_TICKS));
    base = dut_gt;
    run_frames(2);
    check("step_no_repeat", 32'(dut_gt - base), 32'd0);

    // Speed 3 -> 1 mid-frame, then speed 0 behaves as 1
    run_cycles(3);
    pulse_pause();
    speed = 4'd1;
    run_frames(1);
    base = dut_gt;
    run_frames(3);
    check("speed1_every_frame", 32'(dut_gt - base), 32'd3);
    run_cycles(3);
    speed = 4'd0;
    run_frames(1);
    base = dut_gt;
    run_frames(3);
    check("speed0_as_1", 32'(dut_gt - base), 32'd3);

    // game_over beats pause
    run_cycles(3);
    game_over = 1'b1;
    pause     = 1'b1;
    cyc();
    game_over = 1'b0;
    pause     = 1'b0;
    check("game_over_wins", 32'(state), 32'd0);

    // Reset while a step is pending
    speed = 4'd3;
    run_frames(1);
    pulse_start();
    pulse_pause();
    pulse_step();
    run_cycles(2);
    rst = 1'b1;
    cyc();
    cyc();
    check("rst_state", 32'(state), 32'd0);
    check("rst_game_tick", 32'(game_tick), 32'd0);
    check("rst_pix_en", 32'(pix_en), 32'd0);
    check("rst_frame_tick", 32'(frame_tick), 32'd0);
    rst = 1'b0;
    base = dut_gt;
    run_frames(2);
    check("post_rst_no_ticks", 32'(dut_gt - base), 32'd0);

    // Randomized control traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r         = int'($urandom_range(0, 999));
      rst       = (r < 3);
      game_over = (r >= 3 && r < 10);
      pause     = (r >= 10 && r < 40);
      step      = (r >= 40 && r < 80);
      start     = (r >= 80 && r < 120);
      if ($urandom_range(0, 59) == 0) speed = SW'($urandom_range(0, 15));
      cyc();
    end
    rst = 1'b0; game_over = 1'b0; pause = 1'b0; step = 1'b0; start = 1'b0;
    run_cycles(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, mis_count);
    $finish;
  end

endmodule
